// File: rtl/port_rd_backend.sv
// Per-port egress read backend: queues packet descriptors, fetches the words
// through a request/grant SRAM read port and replays them with sop/vld/eop framing.
module port_rd_backend #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          desc_vld,
  input  logic [4:0]    desc_sram,
  input  logic [10:0]   desc_head,
  input  logic [8:0]    desc_length,
  output logic          desc_rdy,
  output logic [CW-1:0] desc_cnt,
  output logic          sram_rd_req,
  output logic [4:0]    sram_rd_idx,
  output logic [10:0]   sram_rd_addr,
  input  logic          sram_rd_gnt,
  input  logic [15:0]   sram_rd_data,
  input  logic          ready,
  output logic          rd_sop,
  output logic          rd_vld,
  output logic [15:0]   rd_data,
  output logic          rd_eop
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SOP   = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_EOP   = 3'd4;

  typedef struct packed {
    logic [4:0]  sram;
    logic [10:0] head;
    logic [8:0]  length;
  } desc_t;

  desc_t         fifo_mem [DEPTH];
  desc_t         head_desc;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    state;
  logic [8:0]    length, req_cnt, ret_cnt;
  logic          gnt_q;
  logic          push, pop, gnt_hit, req_last;

  assign desc_rdy  = desc_cnt < CW'(DEPTH);
  assign push      = desc_vld && desc_rdy;
  assign head_desc = fifo_mem[rd_ptr];
  // Packet starts are only decided in IDLE or in the EOP cycle of the previous packet.
  assign pop       = (desc_cnt != '0) && ready && (state == S_IDLE || state == S_EOP);
  assign gnt_hit   = sram_rd_req && sram_rd_gnt;
  assign req_last  = ({1'b0, req_cnt} + 10'd1) == {1'b0, length};

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{sram: desc_sram, head: desc_head, length: desc_length};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      desc_cnt     <= '0;
      state        <= S_IDLE;
      length       <= '0;
      req_cnt      <= '0;
      ret_cnt      <= '0;
      gnt_q        <= 1'b0;
      sram_rd_req  <= 1'b0;
      sram_rd_idx  <= '0;
      sram_rd_addr <= '0;
      rd_sop       <= 1'b0;
      rd_vld       <= 1'b0;
      rd_data      <= '0;
      rd_eop       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      desc_cnt <= desc_cnt + CW'(push) - CW'(pop);

      // Read data arrives one cycle after its grant; register it straight out.
      gnt_q   <= gnt_hit;
      rd_vld  <= gnt_q;
      rd_data <= gnt_q ? sram_rd_data : '0;
      if (gnt_q) ret_cnt <= ret_cnt + 9'd1;

      if (gnt_hit) begin
        req_cnt      <= req_cnt + 9'd1;
        sram_rd_addr <= sram_rd_addr + 11'd1;
        if (req_last) sram_rd_req <= 1'b0;
      end

      rd_sop <= 1'b0;
      rd_eop <= 1'b0;
      case (state)
        S_IDLE, S_EOP: begin
          state <= S_IDLE;
          // Zero-length descriptors are popped and dropped without framing.
          if (pop && head_desc.length != '0) begin
            state        <= S_SOP;
            rd_sop       <= 1'b1;
            sram_rd_req  <= 1'b1;
            sram_rd_idx  <= head_desc.sram;
            sram_rd_addr <= head_desc.head;
            length       <= head_desc.length;
            req_cnt      <= '0;
            ret_cnt      <= '0;
          end
        end
        S_SOP:   state <= S_READ;
        S_READ:  if (req_cnt == length) state <= S_DRAIN;
        S_DRAIN: begin
          if (ret_cnt == length) begin
            state  <= S_EOP;
            rd_eop <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_rd_backend.sv
// Scoreboard bench for port_rd_backend: SRAM responder plus packet-level reference model.
module tb_port_rd_backend;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_vld = 1'b0;
  logic [4:0]  desc_sram = '0;
  logic [10:0] desc_head = '0;
  logic [8:0]  desc_length = '0;
  logic        desc_rdy;
  logic [3:0]  desc_cnt;
  logic        sram_rd_req;
  logic [4:0]  sram_rd_idx;
  logic [10:0] sram_rd_addr;
  logic        sram_rd_gnt = 1'b0;
  logic [15:0] sram_rd_data = '0;
  logic        ready = 1'b0;
  logic        rd_sop, rd_vld, rd_eop;
  logic [15:0] rd_data;

  always #5 clk = ~clk;

  port_rd_backend #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .desc_vld(desc_vld), .desc_sram(desc_sram), .desc_head(desc_head), .desc_length(desc_length),
    .desc_rdy(desc_rdy), .desc_cnt(desc_cnt),
    .sram_rd_req(sram_rd_req), .sram_rd_idx(sram_rd_idx), .sram_rd_addr(sram_rd_addr),
    .sram_rd_gnt(sram_rd_gnt), .sram_rd_data(sram_rd_data),
    .ready(ready), .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_data(rd_data), .rd_eop(rd_eop)
  );

  typedef struct {
    logic [4:0]  s;
    logic [10:0] h;
    logic [8:0]  l;
  } d_t;

  d_t exp_q[$];
  d_t req_q[$];
  int n_checks = 0, n_fail = 0, cyc = 0;
  int gmode = 0;
  bit chk_b2b = 0;
  int sop_count = 0, vld_count = 0, pkts_done = 0;
  logic pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM contents: unique word per (sram, addr)
  function automatic logic [15:0] mem(input logic [4:0] i, input logic [10:0] a);
    return {i, a} ^ 16'h5A3C;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor + SRAM responder, acting at the falling edge
  logic [15:0] words[$];
  bit          in_pkt = 0, full = 0, first = 0, last_eop_b2b = 0;
  int          sop_cyc = 0, last_vld = 0, last_eop = 0, cur_len = 0;
  logic [4:0]  cur_idx = '0;
  logic [10:0] cur_addr = '0;
  int          left = 0, pidx = 0;
  bit          pend_vld = 0;
  logic [15:0] pend_data = '0;
  logic [1:0]  hit_d = '0;

  always @(negedge clk) begin
    d_t  d;
    bit  g, hit;
    if (rst) begin
      in_pkt = 0; words.delete(); exp_q.delete(); req_q.delete();
      hit_d = '0; pend_vld = 0; left = 0; last_eop_b2b = 0;
      sram_rd_gnt = 1'b0; sram_rd_data = 16'($urandom);
    end else begin
      chk("vld_timing", rd_vld, hit_d[1]);
      if (!rd_vld) chk("data_idle_zero", rd_data, 0);
      if (!chk_b2b) last_eop_b2b = 0;
      if (rd_sop) begin
        sop_count++;
        if (in_pkt || exp_q.size() == 0) chk("sop_unexpected", 1, 0);
        else begin
          d = exp_q.pop_front();
          words.delete();
          for (int i = 0; i < int'(d.l); i++) words.push_back(mem(d.s, d.h + 11'(i)));
          in_pkt = 1; sop_cyc = cyc; cur_len = int'(d.l); full = (gmode == 0); first = 1;
          if (chk_b2b && last_eop_b2b) chk("b2b_gap", cyc - last_eop, 1);
        end
      end
      if (rd_vld) begin
        vld_count++;
        if (!in_pkt || words.size() == 0) chk("vld_outside_pkt", 1, 0);
        else begin
          chk("rd_data", rd_data, words.pop_front());
          if (full && first) chk("first_vld_lat", cyc - sop_cyc, 2);
        end
        first = 0; last_vld = cyc;
      end
      if (rd_eop) begin
        if (!in_pkt) chk("eop_unexpected", 1, 0);
        else begin
          chk("words_left", words.size(), 0);
          chk("eop_after_last", cyc - last_vld, 1);
          if (full) chk("pkt_span", cyc - sop_cyc, cur_len + 2);
          in_pkt = 0; pkts_done++; last_eop = cyc; last_eop_b2b = chk_b2b;
        end
      end

      if (rd_sop && req_q.size() > 0) begin
        d = req_q.pop_front();
        cur_idx = d.s; cur_addr = d.h; left = int'(d.l); pidx = 0;
      end
      case (gmode)
        0:       g = 1'b1;
        1:       g = ($urandom_range(0, 3) != 0);
        default: g = (pidx < 8) ? pat[pidx] : 1'b1;
      endcase
      pidx++;
      hit = sram_rd_req && g;
      sram_rd_gnt  = g;
      sram_rd_data = pend_vld ? pend_data : 16'($urandom);
      pend_vld = hit;
      if (hit) begin
        if (left == 0) chk("extra_req", 1, 0);
        else begin
          chk("rd_idx", sram_rd_idx, cur_idx);
          chk("rd_addr", sram_rd_addr, cur_addr);
          pend_data = mem(sram_rd_idx, sram_rd_addr);
          cur_addr = cur_addr + 11'd1;
          left--;
        end
      end
      hit_d = {hit_d[0], hit};
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [4:0] s, input logic [10:0] h, input logic [8:0] l, output bit acc);
    d_t d;
    desc_vld = 1'b1; desc_sram = s; desc_head = h; desc_length = l;
    acc = desc_rdy;
    if (acc && l != 0) begin
      d.s = s; d.h = h; d.l = l;
      exp_q.push_back(d); req_q.push_back(d);
    end
    step();
    desc_vld = 1'b0;
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int n = 0;
    while (pkts_done < target && n < budget) begin step(); n++; end
    chk("pkts_done_timeout", pkts_done, target);
  endtask

  task automatic chk_reset_outs();
    chk("rst_desc_rdy", desc_rdy, 1);
    chk("rst_desc_cnt", desc_cnt, 0);
    chk("rst_req", sram_rd_req, 0);
    chk("rst_idx", sram_rd_idx, 0);
    chk("rst_addr", sram_rd_addr, 0);
    chk("rst_sop", rd_sop, 0);
    chk("rst_vld", rd_vld, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_eop", rd_eop, 0);
  endtask

  initial begin
    bit acc;
    int nacc, s0, v0, n, base, nexp;
    logic [8:0] l;

    rst = 1'b1;
    repeat (3) step();
    chk_reset_outs();
    rst = 1'b0;
    step();

    // directed single packets
    ready = 1'b1;
    push(5'd3, 11'd100, 9'd4, acc);   chk("accept_first", acc, 1);
    wait_pkts(1, 50);
    push(5'd5, 11'd2046, 9'd4, acc);  wait_pkts(2, 50);
    push(5'd1, 11'd2040, 9'd511, acc); wait_pkts(3, 700);
    gmode = 2;
    push(5'd7, 11'd500, 9'd5, acc);   wait_pkts(4, 60);
    gmode = 0;

    // backpressure, FIFO full, then back-to-back drain
    ready = 1'b0; s0 = sop_count; nacc = 0;
    for (int i = 0; i < 9; i++) begin
      push(5'($urandom), 11'($urandom), 9'($urandom_range(1, 8)), acc);
      nacc += int'(acc);
    end
    chk("ninth_rejected", acc, 0);
    chk("accepted_cnt", nacc, 8);
    chk("full_desc_cnt", desc_cnt, 8);
    chk("full_desc_rdy", desc_rdy, 0);
    repeat (20) step();
    chk("no_output_when_not_ready", sop_count, s0);
    chk_b2b = 1; ready = 1'b1;
    wait_pkts(12, 400);
    chk_b2b = 0;

    // zero-length entry, then ready dropped mid-packet
    ready = 1'b0; s0 = sop_count;
    push(5'd2, 11'd10, 9'd0, acc);
    push(5'd9, 11'd7, 9'd2, acc);
    ready = 1'b1;
    n = 0;
    while (sop_count == s0 && n < 50) begin step(); n++; end
    chk("zero_len_sop_timeout", int'(sop_count > s0), 1);
    step();
    ready = 1'b0;
    wait_pkts(13, 50);
    chk("zero_len_sop_count", sop_count - s0, 1);

    // reset mid-packet with a second descriptor queued
    ready = 1'b1; gmode = 1; v0 = vld_count;
    push(5'd4, 11'd300, 9'd10, acc);
    push(5'd8, 11'd900, 9'd3, acc);
    n = 0;
    while (vld_count == v0 && n < 50) begin step(); n++; end
    chk("mid_rst_vld_timeout", int'(vld_count > v0), 1);
    rst = 1'b1;
    step();
    chk_reset_outs();
    rst = 1'b0;
    repeat (3) step();
    chk("no_eop_after_rst", pkts_done, 13);
    push(5'd6, 11'd1000, 9'd6, acc);
    wait_pkts(14, 100);

    // randomized traffic
    base = pkts_done; nexp = 0;
    for (int i = 0; i < 60; i++) begin
      ready = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        l = 9'($urandom_range(0, 12));
        push(5'($urandom), 11'($urandom), l, acc);
        if (acc && l != 0) nexp++;
      end else step();
    end
    ready = 1'b1;
    wait_pkts(base + nexp, 2000);
    repeat (5) step();
    chk("end_desc_cnt", desc_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
